rs_age_select: RTL and testbench

Parametrised reservation station for the out-of-order backend. It replaces the per-unit single-CDB stations with one generic block instantiated per functional unit. The block holds DEPTH dispatched micro-ops with an opaque payload and wakes source operands from NUM_CDB broadcast ports. Each cycle it issues the oldest fully-ready entry under a valid/ready handshake, with age tracked by an age matrix rather than per-entry counters. It sits between rename_dispatch and the functional unit / register-file read ports.

---
 rtl/rs_age_select_pkg.sv | 20 ++
 rtl/rs_age_select_age_matrix.sv | 40 ++++
 rtl/rs_age_select.sv | 134 +++++++++++++
 tb/tb_rs_age_select.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_age_select_pkg.sv
// Shared types and default sizing for the age-ordered reservation station.
package rs_age_select_pkg;

  localparam int RS_DEPTH     = 8;
  localparam int RS_NUM_CDB   = 2;
  localparam int RS_PREG_W    = 6;
  localparam int RS_PAYLOAD_W = 64;

  typedef logic [RS_PREG_W-1:0] preg_t;

  typedef struct packed {
    logic                    valid;
    preg_t                   ps1;
    logic                    ps1_rdy;
    preg_t                   ps2;
    logic                    ps2_rdy;
    logic [RS_PAYLOAD_W-1:0] payload;
  } rs_entry_t;

endpackage

// File: rtl/rs_age_select_age_matrix.sv
// DEPTH x DEPTH age matrix: older[i][j] means entry i was allocated before entry j.
module rs_age_select_age_matrix #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] grant
);

  logic [DEPTH-1:0] older [DEPTH];
  logic [DEPTH-1:0] blocked;

  // A newly allocated entry is younger than everything; bits of invalid entries are masked by req.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (alloc[i])      older[i][j] <= 1'b0;
          else if (alloc[j]) older[i][j] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    blocked = '0;
    grant   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && req[j] && older[j][i]) blocked[i] = 1'b1;
      end
      grant[i] = req[i] && !blocked[i];
    end
  end

endmodule

// File: rtl/rs_age_select.sv
// Generic reservation station: CDB wakeup CAM, lowest-free allocation, oldest-ready issue.
module rs_age_select
  import rs_age_select_pkg::*;
#(
  parameter int DEPTH     = RS_DEPTH,
  parameter int NUM_CDB   = RS_NUM_CDB,
  parameter int PREG_W    = RS_PREG_W,
  parameter int PAYLOAD_W = RS_PAYLOAD_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             disp_valid,
  output logic                             disp_ready,
  input  logic [PREG_W-1:0]                disp_ps1,
  input  logic [PREG_W-1:0]                disp_ps2,
  input  logic                             disp_ps1_rdy,
  input  logic                             disp_ps2_rdy,
  input  logic [PAYLOAD_W-1:0]             disp_payload,
  input  logic [NUM_CDB-1:0]               cdb_valid,
  input  logic [NUM_CDB-1:0][PREG_W-1:0]   cdb_pd,
  output logic                             iss_valid,
  input  logic                             iss_ready,
  output logic [PREG_W-1:0]                iss_ps1,
  output logic [PREG_W-1:0]                iss_ps2,
  output logic [PAYLOAD_W-1:0]             iss_payload,
  output logic [$clog2(DEPTH+1)-1:0]       free_count
);

  localparam int FC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]     valid, ps1_rdy, ps2_rdy;
  logic [PREG_W-1:0]    ps1 [DEPTH];
  logic [PREG_W-1:0]    ps2 [DEPTH];
  logic [PAYLOAD_W-1:0] payload [DEPTH];

  logic [DEPTH-1:0] alloc_oh, alloc_en, cand, grant, clr;
  logic [DEPTH-1:0] wake1, wake2;
  logic             disp_hit1, disp_hit2, alloc_found;
  logic             disp_fire, iss_fire;
  logic [FC_W-1:0]  cnt;

  // Wakeup CAM for stored operands plus the dispatch-cycle bypass match.
  always_comb begin
    wake1     = '0;
    wake2     = '0;
    disp_hit1 = 1'b0;
    disp_hit2 = 1'b0;
    for (int p = 0; p < NUM_CDB; p++) begin
      if (cdb_valid[p] && cdb_pd[p] == disp_ps1) disp_hit1 = 1'b1;
      if (cdb_valid[p] && cdb_pd[p] == disp_ps2) disp_hit2 = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (cdb_valid[p] && cdb_pd[p] == ps1[i]) wake1[i] = 1'b1;
        if (cdb_valid[p] && cdb_pd[p] == ps2[i]) wake2[i] = 1'b1;
      end
    end
  end

  always_comb begin
    cnt         = '0;
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + {{(FC_W-1){1'b0}}, ~valid[i]};
      if (!valid[i] && !alloc_found) begin
        alloc_oh[i] = 1'b1;
        alloc_found = 1'b1;
      end
    end
  end

  // Both ports transfer only on valid && ready in the same cycle; valid never depends on ready.
  assign free_count = cnt;
  assign disp_ready = rst && (cnt != '0) && !flush;
  assign disp_fire  = disp_valid && disp_ready;
  assign alloc_en   = alloc_oh & {DEPTH{disp_fire}};

  assign cand      = valid & ps1_rdy & ps2_rdy;
  assign iss_valid = (|cand) && !flush;
  assign iss_fire  = iss_valid && iss_ready;
  assign clr       = grant & {DEPTH{iss_fire}};

  rs_age_select_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk   (clk),
    .rst   (rst),
    .alloc (alloc_en),
    .req   (cand),
    .grant (grant)
  );

  always_comb begin
    iss_ps1     = '0;
    iss_ps2     = '0;
    iss_payload = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i] && iss_valid) begin
        iss_ps1     = iss_ps1 | ps1[i];
        iss_ps2     = iss_ps2 | ps2[i];
        iss_payload = iss_payload | payload[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid   <= '0;
      ps1_rdy <= '0;
      ps2_rdy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ps1[i]     <= '0;
        ps2[i]     <= '0;
        payload[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush) begin
          valid[i] <= 1'b0;
        end else if (alloc_en[i]) begin
          valid[i]   <= 1'b1;
          ps1[i]     <= disp_ps1;
          ps2[i]     <= disp_ps2;
          ps1_rdy[i] <= disp_ps1_rdy || disp_hit1;
          ps2_rdy[i] <= disp_ps2_rdy || disp_hit2;
          payload[i] <= disp_payload;
        end else begin
          if (clr[i])   valid[i]   <= 1'b0;
          if (wake1[i]) ps1_rdy[i] <= 1'b1;
          if (wake2[i]) ps2_rdy[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_age_select.sv
// Bench for rs_age_select: directed scenarios plus random traffic against an in-order list model.
module tb_rs_age_select;

  localparam int DEPTH     = 8;
  localparam int NUM_CDB   = 2;
  localparam int PREG_W    = 6;
  localparam int PAYLOAD_W = 64;

  logic                           clk = 1'b0;
  logic                           rst;
  logic                           flush;
  logic                           disp_valid;
  logic                           disp_ready;
  logic [PREG_W-1:0]              disp_ps1, disp_ps2;
  logic                           disp_ps1_rdy, disp_ps2_rdy;
  logic [PAYLOAD_W-1:0]           disp_payload;
  logic [NUM_CDB-1:0]             cdb_valid;
  logic [NUM_CDB-1:0][PREG_W-1:0] cdb_pd;
  logic                           iss_valid;
  logic                           iss_ready;
  logic [PREG_W-1:0]              iss_ps1, iss_ps2;
  logic [PAYLOAD_W-1:0]           iss_payload;
  logic [$clog2(DEPTH+1)-1:0]     free_count;

  rs_age_select #(
    .DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .disp_valid   (disp_valid),
    .disp_ready   (disp_ready),
    .disp_ps1     (disp_ps1),
    .disp_ps2     (disp_ps2),
    .disp_ps1_rdy (disp_ps1_rdy),
    .disp_ps2_rdy (disp_ps2_rdy),
    .disp_payload (disp_payload),
    .cdb_valid    (cdb_valid),
    .cdb_pd       (cdb_pd),
    .iss_valid    (iss_valid),
    .iss_ready    (iss_ready),
    .iss_ps1      (iss_ps1),
    .iss_ps2      (iss_ps2),
    .iss_payload  (iss_payload),
    .free_count   (free_count)
  );

  always #5 clk = ~clk;

  // Model: waiting micro-ops kept in dispatch order, so the oldest ready one is the first ready one.
  typedef struct {
    logic [PREG_W-1:0]    ps1;
    bit                   r1;
    logic [PREG_W-1:0]    ps2;
    bit                   r2;
    logic [PAYLOAD_W-1:0] pl;
  } m_t;

  m_t                   mq[$];
  logic [PAYLOAD_W-1:0] exp_q[$];
  int                   n_tests = 0;
  int                   n_fail  = 0;
  bit                   done    = 1'b0;
  int                   tag     = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [PREG_W-1:0] p);
    bit h = 1'b0;
    for (int k = 0; k < NUM_CDB; k++)
      if (cdb_valid[k] && cdb_pd[k] == p) h = 1'b1;
    return h;
  endfunction

  // One cycle of stimulus, applied at a falling edge.
  task automatic step(input bit dv, input logic [PREG_W-1:0] p1, input bit r1,
                      input logic [PREG_W-1:0] p2, input bit r2,
                      input logic [1:0] cv, input logic [PREG_W-1:0] c0,
                      input logic [PREG_W-1:0] c1, input bit ir, input bit fl);
    disp_valid   = dv;
    disp_ps1     = p1;
    disp_ps1_rdy = r1;
    disp_ps2     = p2;
    disp_ps2_rdy = r2;
    disp_payload = {32'(tag), 32'($urandom())};
    tag++;
    cdb_valid    = cv;
    cdb_pd[0]    = c0;
    cdb_pd[1]    = c1;
    iss_ready    = ir;
    flush        = fl;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit ir);
    repeat (n) step(1'b0, '0, 1'b0, '0, 1'b0, 2'b00, '0, '0, ir, 1'b0);
  endtask

  task automatic do_flush();
    step(1'b0, '0, 1'b0, '0, 1'b0, 2'b00, '0, '0, 1'b0, 1'b1);
  endtask

  // Reference model: evaluates the pre-edge view, predicts outputs, then advances to post-edge state.
  initial begin
    int   idx;
    bit   exp_iv, exp_dr, fire;
    m_t   e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && !done) begin
        idx = -1;
        for (int i = 0; i < mq.size(); i++)
          if (idx < 0 && mq[i].r1 && mq[i].r2) idx = i;
        exp_iv = (idx >= 0) && !flush;
        exp_dr = (mq.size() < DEPTH) && !flush;
        check("iss_valid", 64'(iss_valid), 64'(exp_iv));
        check("free_count", 64'(free_count), 64'(DEPTH - mq.size()));
        check("disp_ready", 64'(disp_ready), 64'(exp_dr));
        if (exp_iv) begin
          check("iss_payload", iss_payload, mq[idx].pl);
          check("iss_ps1", 64'(iss_ps1), 64'(mq[idx].ps1));
          check("iss_ps2", 64'(iss_ps2), 64'(mq[idx].ps2));
        end else begin
          check("iss_payload_idle", iss_payload, 64'd0);
        end
        fire = exp_iv && iss_ready;
        if (fire) exp_q.push_back(mq[idx].pl);
        if (flush) begin
          mq.delete();
        end else begin
          if (fire) mq.delete(idx);
          for (int i = 0; i < mq.size(); i++) begin
            e = mq[i];
            if (hit(e.ps1)) e.r1 = 1'b1;
            if (hit(e.ps2)) e.r2 = 1'b1;
            mq[i] = e;
          end
          if (disp_valid && exp_dr) begin
            e.ps1 = disp_ps1;
            e.r1  = disp_ps1_rdy || hit(disp_ps1);
            e.ps2 = disp_ps2;
            e.r2  = disp_ps2_rdy || hit(disp_ps2);
            e.pl  = disp_payload;
            mq.push_back(e);
          end
        end
      end
    end
  end

  // Monitor: every accepted issue must match the next expected micro-op.
  initial begin
    logic [PAYLOAD_W-1:0] exp_pl;
    forever begin
      @(negedge clk);
      #3;
      if (rst && !done && iss_valid && iss_ready) begin
        if (exp_q.size() == 0) begin
          check("issue_unexpected", iss_payload, 64'd0);
        end else begin
          exp_pl = exp_q.pop_front();
          check("issue_order", iss_payload, exp_pl);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    step(1'b0, '0, 1'b0, '0, 1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
    check("rst_iss_valid", 64'(iss_valid), 64'd0);
    check("rst_free_count", 64'(free_count), 64'(DEPTH));
    check("rst_disp_ready", 64'(disp_ready), 64'd0);
    check("rst_iss_payload", iss_payload, 64'd0);
    rst = 1'b1;

    // Idle after reset: no spurious issue.
    idle(20, 1'b1);

    // Age order: A waits on p5, B and C issue first, then A after broadcast.
    step(1'b1, 6'd5, 1'b0, 6'd1, 1'b1, 2'b00, '0, '0, 1'b0, 1'b0);
    step(1'b1, 6'd2, 1'b1, 6'd3, 1'b1, 2'b00, '0, '0, 1'b0, 1'b0);
    step(1'b1, 6'd4, 1'b1, 6'd3, 1'b1, 2'b00, '0, '0, 1'b1, 1'b0);
    idle(2, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b0, 2'b01, 6'd5, '0, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Out-of-index age: slots 2 and 5 drain first and are refilled by the youngest ops.
    do_flush();
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, (i == 2 || i == 5) ? 6'd40 : 6'd30, 1'b0, 6'd1, 1'b1, 2'b00, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0, 2'b01, 6'd40, '0, 1'b1, 1'b0);
    idle(2, 1'b1);
    step(1'b1, 6'd30, 1'b0, 6'd1, 1'b1, 2'b00, '0, '0, 1'b0, 1'b0);
    step(1'b1, 6'd30, 1'b0, 6'd1, 1'b1, 2'b00, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0, 2'b10, '0, 6'd30, 1'b0, 1'b0);
    idle(10, 1'b1);

    // Multi-port bypass wakeup in the dispatch cycle.
    step(1'b1, 6'd7, 1'b0, 6'd9, 1'b0, 2'b11, 6'd7, 6'd9, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Full with backpressure, then release one.
    do_flush();
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 6'(i), 1'b1, 6'(i + 1), 1'b1, 2'b00, '0, '0, 1'b0, 1'b0);
    repeat (3) step(1'b1, 6'd3, 1'b1, 6'd3, 1'b1, 2'b00, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0, 2'b00, '0, '0, 1'b1, 1'b0);
    step(1'b1, 6'd3, 1'b1, 6'd3, 1'b1, 2'b00, '0, '0, 1'b0, 1'b0);
    idle(10, 1'b1);

    // Flush mid-stream with dispatch and issue requested.
    for (int i = 0; i < 5; i++)
      step(1'b1, 6'(i), 1'b1, 6'(i), 1'b1, 2'b00, '0, '0, 1'b0, 1'b0);
    step(1'b1, 6'd1, 1'b1, 6'd1, 1'b1, 2'b00, '0, '0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Random traffic.
    repeat (1500) begin
      step(($urandom_range(0, 9) < 7), 6'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           6'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) == 0));
    end
    idle(DEPTH + 2, 1'b1);

    done = 1'b1;
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
